// File: rtl/demux_1x4_seq_pkg.sv
// Shared constants and pointer-state type for the registered 1-to-4 demultiplexer.
// Channel count, select width, mode encodings and the round-robin pointer states.
package demux_1x4_seq_pkg;

    localparam int   NUM_CH        = 4;
    localparam int   SEL_W         = 2;
    localparam logic MODE_EXPLICIT = 1'b0;
    localparam logic MODE_AUTO     = 1'b1;

    typedef enum logic [SEL_W-1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } ptr_state_t;

    // S3 wraps back to S0 through the natural 2-bit overflow.
    function automatic ptr_state_t ptr_advance(input ptr_state_t s);
        logic [SEL_W-1:0] nxt;
        nxt = s + 2'd1;
        return ptr_state_t'(nxt);
    endfunction

endpackage

// File: rtl/demux_1x4_seq_decoder_2x4.sv
// Combinational 2-to-4 one-hot decoder with an enable.
// Produces the channel write-enables, which are also registered as y_valid.
module demux_1x4_seq_decoder_2x4
    import demux_1x4_seq_pkg::*;
(
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              en_i,
    output logic [NUM_CH-1:0] onehot_o
);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dec
            assign onehot_o[gi] = en_i && (sel_i == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/demux_1x4_seq.sv
// Registered 1-to-4 demultiplexer: explicit channel select or round-robin frame reassembly.
// All outputs come straight from registers; the pointer FSM and frame snapshot live here.
module demux_1x4_seq
    import demux_1x4_seq_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [WIDTH-1:0]        din,
    input  logic                    din_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    auto_mode,
    output logic [NUM_CH*WIDTH-1:0] Y,
    output logic [NUM_CH-1:0]       y_valid,
    output logic [SEL_W-1:0]        ptr,
    output logic                    frame_done,
    output logic [NUM_CH*WIDTH-1:0] frame_word
);

    ptr_state_t                    ptr_q;
    ptr_state_t                    ptr_d;
    logic [NUM_CH-1:0][WIDTH-1:0]  y_q;
    logic [NUM_CH-1:0]             y_valid_q;
    logic                          frame_done_q;
    logic [NUM_CH*WIDTH-1:0]       frame_word_q;
    logic [NUM_CH*WIDTH-1:0]       frame_word_d;
    logic [SEL_W-1:0]              ch_sel;
    logic [NUM_CH-1:0]             wr_en;

    assign ch_sel = (auto_mode == MODE_EXPLICIT) ? sel : ptr_q;
    assign ptr_d  = ptr_advance(ptr_q);

    // The closing word is taken from din directly; channel 3 is only written on this same edge.
    assign frame_word_d = {din, y_q[2], y_q[1], y_q[0]};

    demux_1x4_seq_decoder_2x4 u_decoder_2x4 (
        .sel_i    (ch_sel),
        .en_i     (din_valid),
        .onehot_o (wr_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= S0;
            y_q          <= '0;
            y_valid_q    <= '0;
            frame_done_q <= 1'b0;
            frame_word_q <= '0;
        end else if (clear) begin
            ptr_q        <= S0;
            y_q          <= '0;
            y_valid_q    <= '0;
            frame_done_q <= 1'b0;
            frame_word_q <= '0;
        end else begin
            y_valid_q    <= wr_en;
            frame_done_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en[k]) begin
                    y_q[k] <= din;
                end
            end
            // Leaving auto mode abandons any partial frame so the next one starts at channel 0.
            if (auto_mode != MODE_AUTO) begin
                ptr_q <= S0;
            end else if (din_valid) begin
                ptr_q <= ptr_d;
                if (ptr_q == S3) begin
                    frame_done_q <= 1'b1;
                    frame_word_q <= frame_word_d;
                end
            end
        end
    end

    assign Y          = y_q;
    assign y_valid    = y_valid_q;
    assign ptr        = ptr_q;
    assign frame_done = frame_done_q;
    assign frame_word = frame_word_q;

endmodule

// File: tb/tb_demux_1x4_seq.sv
// Self-checking bench for demux_1x4_seq (WIDTH=4): directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model of frame reassembly.
module tb_demux_1x4_seq;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           clear;
    logic [W-1:0]   din;
    logic           din_valid;
    logic [1:0]     sel;
    logic           auto_mode;
    logic [4*W-1:0] Y;
    logic [3:0]     y_valid;
    logic [1:0]     ptr;
    logic           frame_done;
    logic [4*W-1:0] frame_word;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 0;

    demux_1x4_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .din        (din),
        .din_valid  (din_valid),
        .sel        (sel),
        .auto_mode  (auto_mode),
        .Y          (Y),
        .y_valid    (y_valid),
        .ptr        (ptr),
        .frame_done (frame_done),
        .frame_word (frame_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: channel contents, plus the words of the frame collected so far.
    logic [W-1:0]   m_ch [4];
    logic [W-1:0]   fq [$];
    logic [3:0]     m_yv;
    logic           m_fd;
    logic [4*W-1:0] m_fw;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < 4; i++) m_ch[i] = '0;
            fq.delete();
            m_yv = '0;
            m_fd = 1'b0;
            m_fw = '0;
        end else begin
            m_yv = '0;
            m_fd = 1'b0;
            if (!auto_mode) begin
                fq.delete();
                if (din_valid) begin
                    m_ch[sel] = din;
                    m_yv[sel] = 1'b1;
                end
            end else if (din_valid) begin
                m_ch[fq.size()] = din;
                m_yv[fq.size()] = 1'b1;
                fq.push_back(din);
                if (fq.size() == 4) begin
                    m_fw = {fq[3], fq[2], fq[1], fq[0]};
                    m_fd = 1'b1;
                    fq.delete();
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_Y", 32'(Y), 32'({m_ch[3], m_ch[2], m_ch[1], m_ch[0]}));
            chk("model_y_valid", 32'(y_valid), 32'(m_yv));
            chk("model_ptr", 32'(ptr), 32'(fq.size()));
            chk("model_frame_done", 32'(frame_done), 32'(m_fd));
            chk("model_frame_word", 32'(frame_word), 32'(m_fw));
        end
    end

    task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] s, input logic a);
        din_valid = v;
        din       = d;
        sel       = s;
        auto_mode = a;
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear     = 1'b1;
        din_valid = 1'b1;
        din       = 4'h5;
        @(negedge clk);
        clear     = 1'b0;
        din_valid = 1'b0;
    endtask

    int f0;

    initial begin
        rst_n = 1'b0; clear = 1'b0; din = '0; din_valid = 1'b0; sel = '0; auto_mode = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_Y", 32'(Y), 32'h0);
        chk("reset_frame_word", 32'(frame_word), 32'h0);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // 1: mid-frame asynchronous reset
        step(1, 4'h1, 0, 1); step(1, 4'h2, 0, 1); step(1, 4'h3, 0, 1); step(1, 4'h4, 0, 1);
        chk("t1_frame_word", 32'(frame_word), 32'h4321);
        step(1, 4'h5, 0, 1); step(1, 4'h6, 0, 1);
        chk("t1_ptr_before_reset", 32'(ptr), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_Y", 32'(Y), 32'h0);
        chk("t1_async_y_valid", 32'(y_valid), 32'h0);
        chk("t1_async_ptr", 32'(ptr), 32'h0);
        chk("t1_async_frame_done", 32'(frame_done), 32'h0);
        chk("t1_async_frame_word", 32'(frame_word), 32'h0);
        din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 2: explicit mode
        step(1, 4'hA, 2, 0);
        chk("t2_Y", 32'(Y), 32'h0A00);
        chk("t2_y_valid", 32'(y_valid), 32'b0100);
        chk("t2_ptr", 32'(ptr), 32'd0);
        step(0, 4'h0, 0, 1);
        chk("t2_idle_y_valid", 32'(y_valid), 32'h0);

        // 3: auto mode, back-to-back frame
        step(1, 4'h1, 0, 1); chk("t3_yv0", 32'(y_valid), 32'b0001);
        step(1, 4'h2, 0, 1); chk("t3_yv1", 32'(y_valid), 32'b0010);
        step(1, 4'h3, 0, 1); chk("t3_yv2", 32'(y_valid), 32'b0100);
        step(1, 4'h4, 0, 1); chk("t3_yv3", 32'(y_valid), 32'b1000);
        chk("t3_frame_done", 32'(frame_done), 32'd1);
        chk("t3_frame_word", 32'(frame_word), 32'h4321);
        step(0, 4'h0, 0, 1);
        chk("t3_frame_done_off", 32'(frame_done), 32'd0);
        chk("t3_ptr_wrap", 32'(ptr), 32'd0);

        // 4: gaps and clear
        step(1, 4'h5, 0, 1); chk("t4_ptr1", 32'(ptr), 32'd1);
        step(0, 4'h0, 0, 1); chk("t4_ptr1_hold", 32'(ptr), 32'd1);
        step(1, 4'h6, 0, 1); chk("t4_ptr2", 32'(ptr), 32'd2);
        step(0, 4'h0, 0, 1); chk("t4_ptr2_hold", 32'(ptr), 32'd2);
        do_clear();
        chk("t4_clear_Y", 32'(Y), 32'h0);
        chk("t4_clear_ptr", 32'(ptr), 32'd0);
        chk("t4_clear_y_valid", 32'(y_valid), 32'h0);
        step(1, 4'h7, 0, 1); step(1, 4'h8, 0, 1); step(1, 4'h9, 0, 1); step(1, 4'hA, 0, 1);
        chk("t4_frame_word", 32'(frame_word), 32'hA987);
        chk("t4_frame_done", 32'(frame_done), 32'd1);

        // 5: mode switch abandons the partial frame
        step(1, 4'h1, 0, 1); chk("t5_ptr1", 32'(ptr), 32'd1);
        step(1, 4'hF, 3, 0);
        chk("t5_explicit_Y", 32'(Y), 32'hF981);
        chk("t5_ptr_forced", 32'(ptr), 32'd0);
        chk("t5_no_frame_done", 32'(frame_done), 32'd0);
        step(1, 4'hB, 0, 1); chk("t5_restart_yv", 32'(y_valid), 32'b0001);
        step(1, 4'hC, 0, 1); step(1, 4'hD, 0, 1); step(1, 4'hE, 0, 1);
        chk("t5_frame_word", 32'(frame_word), 32'hEDCB);
        chk("t5_ptr_end", 32'(ptr), 32'd0);

        // 6: randomized traffic
        for (int it = 0; it < 10; it++) begin
            f0 = n_fail;
            for (int c = 0; c < 16; c++) begin
                clear = ($urandom_range(0, 31) == 0);
                step($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom),
                     $urandom_range(0, 4) != 0);
                clear = 1'b0;
            end
            $display("ITER %0d cycles=16 errors=%0d ptr=%0d frame_word=%h", it, n_fail - f0, ptr, frame_word);
        end

        din_valid = 1'b0;
        @(negedge clk);
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1x4_seq.md
Name: demux_1x4_seq

Overview:
Registered 1-to-4 demultiplexer. It routes a WIDTH-bit input lane to one of four output channel registers, so it is the receiving end of Mux_4x1 when that mux is used as a time-division serializer.
- Explicit mode: the caller supplies sel.
- Auto mode: an internal round-robin pointer (0..3) chooses the channel and reassembles each 4-word frame.
- Sits after a mux-based serial link to rebuild parallel channel data.

Parameters:
WIDTH, 1, bit width of each data lane and each channel register.

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous clear of all state; highest priority below reset.
din  input  WIDTH  incoming data lane.
din_valid  input  1  din is accepted on this rising edge.
sel  input  2  destination channel in explicit mode; ignored in auto mode.
auto_mode  input  1  1 = round-robin pointer selects the channel; 0 = sel selects it.
Y  output  4*WIDTH  channel registers; channel k occupies Y[k*WIDTH +: WIDTH].
y_valid  output  4  one-hot strobe, 1 cycle, marks the channel written on the previous edge.
ptr  output  2  current auto-mode pointer.
frame_done  output  1  1-cycle pulse when an auto-mode frame completes.
frame_word  output  4*WIDTH  snapshot of the last completed frame, channel 0 in the LSBs.

Behaviour:
Reset:
- rst_n low clears all outputs immediately (asynchronous): Y=0, y_valid=0, ptr=0, frame_done=0, frame_word=0.
- Deassertion takes effect at the next clk edge.

Priority at each edge: rst_n > clear > din_valid > idle.

clear=1:
- Y=0, ptr=0, y_valid=0, frame_done=0, frame_word=0.
- din_valid is ignored on that edge.

Channel select:
- c = auto_mode ? ptr : sel.

Accept (din_valid=1):
- Y[c] <= din.
- y_valid <= one-hot(c).
- Other channels hold their value.
- Latency is 1 cycle from accept to Y and y_valid.

Idle (din_valid=0):
- y_valid <= 0 and frame_done <= 0.
- All other state holds, including ptr.

Pointer FSM, states S0..S3 (ptr value):
- In auto mode, each accept advances ptr by 1 and wraps S3 -> S0.
- Accept in S3:
  - frame_word <= {din, Y[2], Y[1], Y[0]}, i.e. the new word is included.
  - frame_done <= 1 for exactly 1 cycle.
- frame_done and y_valid[3] assert in the same cycle.
- While auto_mode=0, ptr is forced to 0 on every edge. A partial frame is abandoned and the next auto frame always starts at channel 0.
- An explicit-mode accept never touches frame_word or frame_done.

Boundary cases:
- Back-to-back valids are accepted every cycle, with no bubble at wrap-around.
- Switching auto_mode in the same cycle as a valid: the select uses that cycle's auto_mode value.
- An asynchronous reset in the middle of a frame discards the partial frame.
- All outputs are registered; no combinational path exists from inputs to outputs.

Decomposition:
- Shared header: NUM_CH=4, SEL_W=2, and mode encodings MODE_EXPLICIT=0, MODE_AUTO=1.
- Sub-module decoder_2x4: combinational 2-bit to one-hot enable. It drives the channel write-enables and y_valid.
- The pointer FSM and frame assembly stay in the top module.

Test Plan (WIDTH=4 unless stated):
1. Reset: run auto mode, then drop rst_n between edges -> Y, y_valid, ptr, frame_done and frame_word read 0 before the next edge.
2. Explicit mode: auto_mode=0, sel=2, din=4'hA, din_valid=1 for one cycle -> next cycle Y[11:8]=4'hA, y_valid=4'b0100, Y[15:12], Y[7:0] unchanged, ptr=0.
3. Auto mode, back-to-back: din=1,2,3,4 on 4 consecutive valids -> y_valid = 0001, 0010, 0100, 1000; in the 4th output cycle frame_done=1 and frame_word=16'h4321; next cycle frame_done=0, ptr=0.
4. Gaps and clear:
   - Feed 5 and 6 with idle cycles between them -> ptr holds at 1, then 2.
   - Pulse clear -> Y=0, ptr=0.
   - Feed 7,8,9,A -> frame_word=16'hA987.
5. Mode switch: auto mode, accept 1 word (ptr=1); set auto_mode=0, sel=3, din=F; set auto_mode=1 and feed 4 words B,C,D,E -> ptr restarts at 0, frame_word=16'hEDCB.
6. Randomized: 10 iterations of random din, sel, din_valid and auto_mode against a reference model -> Y, y_valid and frame_word match on every cycle, printed per iteration with $display.
